cpu_mem_bridge: RTL and testbench

//  Converts the PicoRV32 native memory handshake (valid/ready) into the single-cycle

---
 rtl/cpu_mem_bridge.sv | 183 ++++++++++++++++++
 tb/tb_cpu_mem_bridge.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_bridge.sv
// rtl/cpu_mem_bridge.sv - PicoRV32 valid/ready to RAM pulse and MMIO req/ack bridge
//
// Purpose: accepts one CPU memory transaction at a time, decodes it to the RAM
// region, the MMIO window or nothing, and returns a single-cycle ready pulse.
// Unmapped accesses and accesses that hang past TIMEOUT wait cycles complete
// with zero read data and set the sticky bus error flag.
//
// Ports:
//   clk, resetn                      clock, asynchronous active-low reset
//   conf_sel_i                       RAM under configuration, hold off new accepts
//   cpu_mem_*_i / cpu_mem_ready_o    PicoRV32 native memory interface
//   cpu_mem_rdata_o                  read data, valid with cpu_mem_ready_o
//   ram_wren_o / ram_rden_o          one-cycle RAM request pulses (accept cycle)
//   ram_addr_o/wstrb_o/wdata_o       RAM word address, strobes, data (accept cycle)
//   ram_rdata_i / ram_ready_i        RAM completion
//   mmio_req_o ... mmio_wdata_o      MMIO level request and latched fields
//   mmio_ack_i / mmio_rdata_i        MMIO completion
//   bus_err_o / err_addr_o           sticky error flag and first error address
module cpu_mem_bridge #(
    parameter int          RAM_AW    = 17,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter logic [31:0] MMIO_MASK = 32'hF000_0000,
    parameter int          TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        conf_sel_i,
    input  logic        cpu_mem_valid_i,
    input  logic        cpu_mem_instr_i,
    input  logic [31:0] cpu_mem_addr_i,
    input  logic [31:0] cpu_mem_wdata_i,
    input  logic [3:0]  cpu_mem_wstrb_i,
    output logic        cpu_mem_ready_o,
    output logic [31:0] cpu_mem_rdata_o,
    output logic        ram_wren_o,
    output logic        ram_rden_o,
    output logic [31:0] ram_addr_o,
    output logic [3:0]  ram_wstrb_o,
    output logic [31:0] ram_wdata_o,
    input  logic [31:0] ram_rdata_i,
    input  logic        ram_ready_i,
    output logic        mmio_req_o,
    output logic        mmio_we_o,
    output logic [31:0] mmio_addr_o,
    output logic [3:0]  mmio_wstrb_o,
    output logic [31:0] mmio_wdata_o,
    input  logic        mmio_ack_i,
    input  logic [31:0] mmio_rdata_i,
    output logic        bus_err_o,
    output logic [31:0] err_addr_o
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, RAM_WAIT, MMIO_WAIT, RESP} state_t;

    state_t         state_q;
    logic [CW-1:0]  cnt_q;
    logic           ready_q;
    logic [31:0]    rdata_q;
    logic [31:0]    addr_q;
    logic [31:0]    wdata_q;
    logic [3:0]     wstrb_q;
    logic           wr_q;
    logic           mmio_req_q;
    logic           bus_err_q;
    logic [31:0]    err_addr_q;

    logic           take_d;
    logic           ram_hit_d;
    logic           mmio_hit_d;
    logic           ram_acc_d;
    logic           cnt_max_d;
    logic           err_now_d;
    logic [31:0]    err_addr_d;

    always_comb begin
        // resetn gates the accept so the combinational RAM pulses stay low in reset
        take_d     = resetn && (state_q == IDLE) && cpu_mem_valid_i && !conf_sel_i;
        ram_hit_d  = (cpu_mem_addr_i[31:RAM_AW] == '0);
        mmio_hit_d = ((cpu_mem_addr_i & MMIO_MASK) == MMIO_BASE) && !cpu_mem_instr_i;
        ram_acc_d  = take_d && ram_hit_d;
        cnt_max_d  = (cnt_q == CW'(TIMEOUT));
        // A completion arriving in the same cycle as the timeout wins
        err_now_d  = (take_d && !ram_hit_d && !mmio_hit_d)
                   || ((state_q == RAM_WAIT)  && !ram_ready_i && cnt_max_d)
                   || ((state_q == MMIO_WAIT) && !mmio_ack_i  && cnt_max_d);
        err_addr_d = (state_q == IDLE) ? cpu_mem_addr_i : addr_q;
    end

    assign ram_rden_o   = ram_acc_d && (cpu_mem_wstrb_i == 4'b0000);
    assign ram_wren_o   = ram_acc_d && (cpu_mem_wstrb_i != 4'b0000);
    assign ram_addr_o   = ram_acc_d ? {2'b00, cpu_mem_addr_i[31:2]} : 32'h0;
    assign ram_wstrb_o  = ram_acc_d ? cpu_mem_wstrb_i : 4'b0000;
    assign ram_wdata_o  = ram_acc_d ? cpu_mem_wdata_i : 32'h0;

    assign cpu_mem_ready_o = ready_q;
    assign cpu_mem_rdata_o = rdata_q;
    assign mmio_req_o      = mmio_req_q;
    assign mmio_we_o       = wr_q;
    assign mmio_addr_o     = addr_q;
    assign mmio_wstrb_o    = wstrb_q;
    assign mmio_wdata_o    = wdata_q;
    assign bus_err_o       = bus_err_q;
    assign err_addr_o      = err_addr_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'h0;
            addr_q     <= 32'h0;
            wdata_q    <= 32'h0;
            wstrb_q    <= 4'b0000;
            wr_q       <= 1'b0;
            mmio_req_q <= 1'b0;
            bus_err_q  <= 1'b0;
            err_addr_q <= 32'h0;
        end else begin
            // ready_q is set only on entry to RESP, so it lasts exactly one cycle
            ready_q <= 1'b0;
            if (err_now_d && !bus_err_q) begin
                bus_err_q  <= 1'b1;
                err_addr_q <= err_addr_d;
            end
            case (state_q)
                IDLE: begin
                    if (take_d) begin
                        addr_q  <= cpu_mem_addr_i;
                        wdata_q <= cpu_mem_wdata_i;
                        wstrb_q <= cpu_mem_wstrb_i;
                        wr_q    <= |cpu_mem_wstrb_i;
                        cnt_q   <= '0;
                        if (ram_hit_d) begin
                            state_q <= RAM_WAIT;
                        end else if (mmio_hit_d) begin
                            mmio_req_q <= 1'b1;
                            state_q    <= MMIO_WAIT;
                        end else begin
                            rdata_q <= 32'h0;
                            ready_q <= 1'b1;
                            state_q <= RESP;
                        end
                    end
                end
                RAM_WAIT: begin
                    if (ram_ready_i) begin
                        rdata_q <= wr_q ? 32'h0 : ram_rdata_i;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else if (cnt_max_d) begin
                        rdata_q <= 32'h0;
                        ready_q <= 1'b1;
                        state_q <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                MMIO_WAIT: begin
                    if (mmio_ack_i) begin
                        mmio_req_q <= 1'b0;
                        rdata_q    <= mmio_rdata_i;
                        ready_q    <= 1'b1;
                        state_q    <= RESP;
                    end else if (cnt_max_d) begin
                        mmio_req_q <= 1'b0;
                        rdata_q    <= 32'h0;
                        ready_q    <= 1'b1;
                        state_q    <= RESP;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_mem_bridge.sv
// tb/tb_cpu_mem_bridge.sv - self-checking bench for cpu_mem_bridge
module tb_cpu_mem_bridge;
    localparam int          INF     = 32'h7FFF_FFFF;
    localparam logic [31:0] MMIO_RD = 32'hC0FF_EE00;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        conf_sel = 1'b0;
    logic        valid = 1'b0;
    logic        instr = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [3:0]  wstrb = 4'h0;
    logic        ready;
    logic [31:0] rdata;
    logic        ram_wren, ram_rden;
    logic [31:0] ram_addr, ram_wdata;
    logic [3:0]  ram_wstrb;
    logic [31:0] ram_rdata = 32'h0;
    logic        ram_ready = 1'b0;
    logic        mmio_req, mmio_we;
    logic [31:0] mmio_addr, mmio_wdata;
    logic [3:0]  mmio_wstrb;
    logic        mmio_ack = 1'b0;
    logic [31:0] mmio_rdata = 32'h0;
    logic        bus_err;
    logic [31:0] err_addr;

    cpu_mem_bridge dut (
        .clk(clk), .resetn(resetn), .conf_sel_i(conf_sel),
        .cpu_mem_valid_i(valid), .cpu_mem_instr_i(instr), .cpu_mem_addr_i(addr),
        .cpu_mem_wdata_i(wdata), .cpu_mem_wstrb_i(wstrb),
        .cpu_mem_ready_o(ready), .cpu_mem_rdata_o(rdata),
        .ram_wren_o(ram_wren), .ram_rden_o(ram_rden), .ram_addr_o(ram_addr),
        .ram_wstrb_o(ram_wstrb), .ram_wdata_o(ram_wdata),
        .ram_rdata_i(ram_rdata), .ram_ready_i(ram_ready),
        .mmio_req_o(mmio_req), .mmio_we_o(mmio_we), .mmio_addr_o(mmio_addr),
        .mmio_wstrb_o(mmio_wstrb), .mmio_wdata_o(mmio_wdata),
        .mmio_ack_i(mmio_ack), .mmio_rdata_i(mmio_rdata),
        .bus_err_o(bus_err), .err_addr_o(err_addr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour of the single outstanding transaction
    int          m_acc = -1, m_rdy = -1, m_req_end = -1, m_kind = 0;
    logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0, m_err_addr = 0;
    logic [3:0]  m_wstrb = 0;
    bit          m_chk_rdata = 0;
    int          m_berr_cyc = INF;

    // Behavioural RAM: responds two cycles after a request pulse
    logic [31:0] mem [int];
    int          rr_at = -1;
    logic [31:0] rr_data = 0;
    logic [31:0] last_ram_addr = 0;
    logic [3:0]  last_ram_wstrb = 0;

    function automatic logic [31:0] memrd(input int w);
        return mem.exists(w) ? mem[w] : 32'h0;
    endfunction

    always @(negedge clk) begin
        if (resetn && (ram_rden || ram_wren)) begin
            int w;
            logic [31:0] cur;
            w = int'(ram_addr);
            cur = memrd(w);
            if (ram_wren) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wstrb[b]) cur[8*b +: 8] = ram_wdata[8*b +: 8];
                mem[w] = cur;
            end
            rr_data = ram_rden ? cur : 32'h0;
            rr_at = cyc + 2;
        end
    end

    always @(posedge clk) begin
        #1;
        ram_ready = (cyc == rr_at);
        ram_rdata = (cyc == rr_at) ? rr_data : 32'h5A5A_5A5A;
    end

    // MMIO slave: acks in the ack_delay-th cycle of mmio_req, never if 0
    int ack_delay = 0, req_cnt = 0, req_len = 0;
    always @(posedge clk) begin
        #1;
        if (mmio_req) req_cnt++;
        else begin
            if (req_cnt != 0) req_len = req_cnt;
            req_cnt = 0;
        end
        mmio_ack = mmio_req && (ack_delay != 0) && (req_cnt == ack_delay);
        mmio_rdata = mmio_ack ? MMIO_RD : 32'h0F0F_0F0F;
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (!resetn) begin
            chk("rst_ready", ready, 0);
            chk("rst_rdata", rdata, 0);
            chk("rst_ram_pulse", {ram_rden, ram_wren}, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_mmio_req", mmio_req, 0);
            chk("rst_mmio_addr", mmio_addr, 0);
            chk("rst_bus_err", bus_err, 0);
            chk("rst_err_addr", err_addr, 0);
        end else begin
            bit exp_rd, exp_wr, exp_req;
            exp_rd = (cyc == m_acc) && (m_kind == 1) && (m_wstrb == 0);
            exp_wr = (cyc == m_acc) && (m_kind == 1) && (m_wstrb != 0);
            chk("ram_rden", ram_rden, exp_rd);
            chk("ram_wren", ram_wren, exp_wr);
            if (exp_rd || exp_wr) begin
                chk("ram_addr", ram_addr, m_addr >> 2);
                chk("ram_wstrb", ram_wstrb, m_wstrb);
                if (exp_wr) chk("ram_wdata", ram_wdata, m_wdata);
                last_ram_addr = ram_addr;
                last_ram_wstrb = ram_wstrb;
            end
            chk("cpu_mem_ready", ready, cyc == m_rdy);
            if (cyc == m_rdy && m_chk_rdata) chk("cpu_mem_rdata", rdata, m_rdata);
            exp_req = (m_kind == 2) && (cyc > m_acc) && (cyc <= m_req_end);
            chk("mmio_req", mmio_req, exp_req);
            if (exp_req) begin
                chk("mmio_we", mmio_we, m_wstrb != 0);
                chk("mmio_addr", mmio_addr, m_addr);
                chk("mmio_wstrb", mmio_wstrb, m_wstrb);
                chk("mmio_wdata", mmio_wdata, m_wdata);
            end
            chk("bus_err", bus_err, cyc >= m_berr_cyc);
            if (cyc >= m_berr_cyc) chk("err_addr", err_addr, m_err_addr);
        end
    end

    task automatic note_err(input int c, input logic [31:0] a);
        if (m_berr_cyc == INF) begin
            m_berr_cyc = c;
            m_err_addr = a;
        end
    endtask

    task automatic clear_model();
        m_acc = -1; m_rdy = -1; m_req_end = -1; m_kind = 0; m_chk_rdata = 0;
    endtask

    task automatic set_model(input logic [31:0] a, input logic [31:0] wd,
                             input logic [3:0] ws, input logic ins, input int c);
        m_acc = c; m_addr = a; m_wdata = wd; m_wstrb = ws; m_chk_rdata = 1;
        if (a < 32'h0002_0000) begin
            m_kind = 1;
            m_rdy = c + 3;
            m_rdata = (ws == 0) ? memrd(int'(a >> 2)) : 32'h0;
        end else if (a[31:28] == 4'h1 && !ins) begin
            m_kind = 2;
            if (ack_delay > 0) begin
                m_req_end = c + ack_delay;
                m_rdata = MMIO_RD;
                m_chk_rdata = (ws == 0);
            end else begin
                m_req_end = c + 256;
                m_rdata = 32'h0;
                note_err(c + 257, a);
            end
            m_rdy = m_req_end + 1;
        end else begin
            m_kind = 3;
            m_rdy = c + 1;
            m_rdata = 32'h0;
            note_err(c + 1, a);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                        input logic ins, input bit conf_mid,
                        output int lat, output logic [31:0] rd);
        int t0;
        bit got;
        t0 = cyc;
        got = 0;
        set_model(a, wd, ws, ins, t0);
        addr = a; wdata = wd; wstrb = ws; instr = ins; valid = 1'b1;
        if (conf_mid) begin
            @(posedge clk); #1;
            conf_sel = 1'b1;
        end
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (ready) begin
                got = 1;
                break;
            end
        end
        if (!got) chk("xfer_ready_timeout", 0, 1);
        lat = cyc - t0;
        rd = rdata;
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    int          lat;
    logic [31:0] rd;
    int          seen;

    initial begin
        mem[4] = 32'h1234_5678;
        mem[2] = 32'h1111_1111;
        mem[32'h7FFF] = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(posedge clk); #1;

        xfer(32'h0000_0010, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("rd10_lat", lat, 3);
        chk("rd10_data", rd, 32'h1234_5678);
        chk("rd10_ram_addr", last_ram_addr, 32'h4);

        xfer(32'h0000_0008, 32'hAABB_CCDD, 4'b0110, 0, 0, lat, rd);
        chk("wr8_lat", lat, 3);
        chk("wr8_ram_addr", last_ram_addr, 32'h2);
        chk("wr8_ram_wstrb", last_ram_wstrb, 4'b0110);

        xfer(32'h0000_0008, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("rd8_merged", rd, 32'h11BB_CC11);

        ack_delay = 5;
        xfer(32'h1000_0004, 32'h0000_0055, 4'hF, 0, 0, lat, rd);
        chk("mmio_wr_lat", lat, 6);
        chk("mmio_wr_req_len", req_len, 5);

        ack_delay = 2;
        xfer(32'h1000_0010, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("mmio_rd_lat", lat, 3);
        chk("mmio_rd_data", rd, MMIO_RD);

        xfer(32'h2000_0000, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("unmap_lat", lat, 1);
        chk("unmap_rdata", rd, 0);
        chk("unmap_bus_err", bus_err, 1);
        chk("unmap_err_addr", err_addr, 32'h2000_0000);

        xfer(32'h3000_0000, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("second_err_addr", err_addr, 32'h2000_0000);

        xfer(32'h1000_0000, 32'h0, 4'h0, 1, 0, lat, rd);
        chk("ifetch_mmio_lat", lat, 1);
        chk("ifetch_mmio_rdata", rd, 0);

        ack_delay = 0;
        xfer(32'h1000_0020, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("mmio_to_lat", lat, 257);
        chk("mmio_to_rdata", rd, 0);
        chk("mmio_to_req_len", req_len, 256);

        clear_model();
        conf_sel = 1'b1;
        addr = 32'h0000_0010; wstrb = 4'h0; instr = 1'b0; valid = 1'b1;
        repeat (20) @(posedge clk);
        #1 conf_sel = 1'b0;
        xfer(32'h0000_0010, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("conf_release_lat", lat, 3);
        chk("conf_release_data", rd, 32'h1234_5678);

        xfer(32'h0000_0010, 32'h0, 4'h0, 0, 1, lat, rd);
        chk("conf_mid_lat", lat, 3);
        chk("conf_mid_data", rd, 32'h1234_5678);
        conf_sel = 1'b0;

        set_model(32'h0000_0010, 32'h0, 4'h0, 0, cyc);
        addr = 32'h0000_0010; wstrb = 4'h0; valid = 1'b1;
        @(posedge clk); #1;
        resetn = 1'b0;
        valid = 1'b0;
        clear_model();
        m_berr_cyc = INF;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (ready) seen++;
        end
        chk("reset_abort_no_ready", seen, 0);
        chk("reset_bus_err_clear", bus_err, 0);
        @(posedge clk); #1;

        xfer(32'h0001_FFFC, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("ram_top_lat", lat, 3);
        chk("ram_top_data", rd, 32'hDEAD_BEEF);

        xfer(32'h0002_0000, 32'h0, 4'h0, 0, 0, lat, rd);
        chk("ram_edge_lat", lat, 1);
        chk("ram_edge_err_addr", err_addr, 32'h0002_0000);

        xfer(32'h1000_0000, 32'h0, 4'h0, 1, 0, lat, rd);
        chk("sticky_err_addr", err_addr, 32'h0002_0000);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
